// File: rtl/branch_pkg.sv
// Shared encodings for the ID-stage branch resolution controller.
package branch_pkg;

    // Comparator select encodings; 3'b110 and 3'b111 are reserved and resolve not-taken.
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLEZ = 3'b010;
    localparam logic [2:0] BR_BGTZ = 3'b011;
    localparam logic [2:0] BR_BLTZ = 3'b100;
    localparam logic [2:0] BR_BGEZ = 3'b101;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EVAL = 2'd2
    } br_state_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode-side bundle between the ID stage and the branch controller.
interface branch_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             br_valid;
    logic [2:0]       br_type;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             rs_ready;
    logic             rt_ready;
    logic [WIDTH-1:0] pc_plus4;
    logic [15:0]      imm16;
    logic             kill;
    logic             stall_id;
    logic             resolve_valid;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             flush_if;
    logic [CNT_W-1:0] stall_cnt;

    // Decode stage side: presents branches, observes stall and resolve.
    modport master (
        output br_valid, br_type, rs_val, rt_val, rs_ready, rt_ready,
               pc_plus4, imm16, kill,
        input  stall_id, resolve_valid, br_taken, br_target, flush_if, stall_cnt
    );

    // Controller side.
    modport slave (
        input  br_valid, br_type, rs_val, rt_val, rs_ready, rt_ready,
               pc_plus4, imm16, kill,
        output stall_id, resolve_valid, br_taken, br_target, flush_if, stall_cnt
    );
endinterface

// File: rtl/branch_ctrl_cmp.sv
// Branch comparator: equality tests use both operands, zero tests use signed A only.
module branch_ctrl_cmp
    import branch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       s,
    output logic             out
);

    // Select the branch condition; reserved selects fall through to not-taken.
    always_comb begin
        out = 1'b0;
        case (s)
            BR_BEQ:  out = (A == B);
            BR_BNE:  out = (A != B);
            BR_BLEZ: out = ($signed(A) <= 0);
            BR_BGTZ: out = ($signed(A) > 0);
            BR_BLTZ: out = A[WIDTH-1];
            BR_BGEZ: out = ~A[WIDTH-1];
            default: out = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution controller: waits for forwarded operands, evaluates
// through one comparator, and emits a single-cycle resolve/flush pulse.
//
//   state  | meaning
//   IDLE   | no branch held; accepts a new one when decode presents it
//   WAIT   | branch seen, at least one operand not final yet
//   EVAL   | operands latched, comparator result captured at the next edge
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         reset,
    branch_ctrl_if.slave bus
);

    br_state_t        r_state;
    logic [WIDTH-1:0] r_rs;
    logic [WIDTH-1:0] r_rt;
    logic [2:0]       r_type;
    logic [WIDTH-1:0] r_target;
    logic             r_resolve_valid;
    logic             r_br_taken;
    logic [WIDTH-1:0] r_br_target;
    logic             r_flush_if;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_ready;
    logic             w_stall_id;
    logic [WIDTH-1:0] w_offset;
    logic [WIDTH-1:0] w_target;
    logic             w_cmp_out;

    // Word offset sign-extended and scaled to bytes; the add wraps at 2^WIDTH.
    assign w_offset   = {{(WIDTH-18){bus.imm16[15]}}, bus.imm16, 2'b00};
    assign w_target   = bus.pc_plus4 + w_offset;
    assign w_ready    = bus.rs_ready & bus.rt_ready;
    assign w_stall_id = ((r_state == S_IDLE) & bus.br_valid) |
                        (r_state == S_WAIT) | (r_state == S_EVAL);

    // Only the latched operands reach the comparator.
    branch_ctrl_cmp #(.WIDTH(WIDTH)) u_cmp (
        .A   (r_rs),
        .B   (r_rt),
        .s   (r_type),
        .out (w_cmp_out)
    );

    // Sequencing FSM with operand latches and registered resolve outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_rs            <= '0;
            r_rt            <= '0;
            r_type          <= '0;
            r_target        <= '0;
            r_resolve_valid <= 1'b0;
            r_br_taken      <= 1'b0;
            r_br_target     <= '0;
            r_flush_if      <= 1'b0;
        end else begin
            r_resolve_valid <= 1'b0;
            r_flush_if      <= 1'b0;
            if (bus.kill) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_WAIT: begin
                        if ((r_state == S_WAIT) || bus.br_valid) begin
                            if (w_ready) begin
                                r_rs     <= bus.rs_val;
                                r_rt     <= bus.rt_val;
                                r_type   <= bus.br_type;
                                r_target <= w_target;
                                r_state  <= S_EVAL;
                            end else begin
                                r_state  <= S_WAIT;
                            end
                        end
                    end
                    S_EVAL: begin
                        r_br_taken      <= w_cmp_out;
                        r_br_target     <= r_target;
                        r_resolve_valid <= 1'b1;
                        r_flush_if      <= w_cmp_out;
                        r_state         <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Saturating count of stalled decode cycles; kill deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall_id && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_id      = w_stall_id;
    assign bus.resolve_valid = r_resolve_valid;
    assign bus.br_taken      = r_br_taken;
    assign bus.br_target     = r_br_target;
    assign bus.flush_if      = r_flush_if;
    assign bus.stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: a cycle model of the decode-visible behaviour checked
// every cycle, plus directed branches with hand-computed results.
module tb_branch_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    branch_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    branch_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Branch rule straight from the instruction semantics.
    function automatic bit rule_taken(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (t)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return sa <= 0;
            3'd3:    return sa > 0;
            3'd4:    return sa < 0;
            3'd5:    return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rule_target(input logic [31:0] pc, input logic [15:0] imm);
        longint off;
        off = longint'($signed(imm)) * 4;
        return 32'(longint'(pc) + off);
    endfunction

    // Model: a branch is either absent, waiting for operands, or being evaluated.
    bit          m_wait, m_eval, m_res, m_taken, p_taken;
    logic [31:0] m_target, p_target;
    int          m_cnt;

    always @(posedge clk) begin
        bit st;
        st = m_wait || m_eval || bus.br_valid;
        if (reset) begin
            m_wait = 0; m_eval = 0; m_res = 0; m_taken = 0; m_target = '0; m_cnt = 0;
        end else begin
            if (st && m_cnt < int'(CNT_MAX)) m_cnt++;
            m_res = 0;
            if (bus.kill) begin
                m_wait = 0; m_eval = 0;
            end else if (m_eval) begin
                m_res = 1; m_taken = p_taken; m_target = p_target; m_eval = 0;
            end else if ((m_wait || bus.br_valid) && bus.rs_ready && bus.rt_ready) begin
                p_taken  = rule_taken(bus.br_type, bus.rs_val, bus.rt_val);
                p_target = rule_target(bus.pc_plus4, bus.imm16);
                m_eval = 1; m_wait = 0;
            end else if (bus.br_valid) begin
                m_wait = 1;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        chk("m_stall_id", bus.stall_id, m_wait || m_eval || bus.br_valid);
        chk("m_resolve_valid", bus.resolve_valid, m_res);
        chk("m_flush_if", bus.flush_if, m_res && m_taken);
        chk("m_stall_cnt", bus.stall_cnt, m_cnt);
        if (m_res) begin
            chk("m_br_taken", bus.br_taken, m_taken);
            chk("m_br_target", bus.br_target, m_target);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_branch(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] pc, input logic [15:0] imm, input int waitc,
                             output int nstall, output bit res, output bit tk,
                             output logic [31:0] tgt, output bit fl);
        nstall = 0; res = 0; tk = 0; tgt = '0; fl = 0;
        bus.br_valid = 1'b1; bus.br_type = t; bus.rs_val = rs; bus.rt_val = rt;
        bus.pc_plus4 = pc; bus.imm16 = imm; bus.rs_ready = 1'b1; bus.rt_ready = (waitc == 0);
        for (int i = 0; i < 20 && !res; i++) begin
            @(negedge clk);
            if (bus.stall_id) nstall++;
            if (bus.resolve_valid) begin
                res = 1; tk = bus.br_taken; tgt = bus.br_target; fl = bus.flush_if;
            end
            step();
            if (i + 1 >= waitc) bus.rt_ready = 1'b1;
            if (i >= waitc) bus.br_valid = 1'b0;
        end
        chk("resolve_seen", res, 1);
    endtask

    typedef struct {
        logic [2:0]  t;
        logic [31:0] rs, rt, pc;
        logic [15:0] imm;
        bit          taken;
        logic [31:0] target;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int nst;
        bit rs_seen, tk, fl;
        logic [31:0] tgt;
        n_checks = 0; n_errors = 0;
        reset = 1'b1;
        bus.br_valid = 0; bus.br_type = '0; bus.rs_val = '0; bus.rt_val = '0;
        bus.rs_ready = 0; bus.rt_ready = 0; bus.pc_plus4 = '0; bus.imm16 = '0; bus.kill = 0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_stall_id", bus.stall_id, 0);
        chk("rst_resolve", bus.resolve_valid, 0);
        chk("rst_target", bus.br_target, 0);
        chk("rst_cnt", bus.stall_cnt, 0);
        step();
        reset = 1'b0;
        step();

        // bne taken, operands ready
        do_branch(3'b001, 32'h9000_0800, 32'h0200_0000, 32'h0000_3004, 16'h0004, 0, nst, rs_seen, tk, tgt, fl);
        chk("t1_stall_cycles", nst, 2);
        chk("t1_taken", tk, 1);
        chk("t1_target", tgt, 32'h0000_3014);
        chk("t1_flush", fl, 1);
        @(negedge clk);
        chk("t1_flush_drop", bus.flush_if, 0);
        step();

        vecs[0] = '{3'd0, 32'h5, 32'h6, 32'h0000_1000, 16'h0003, 0, 32'h0000_100C};
        vecs[1] = '{3'd1, 32'h5, 32'h5, 32'h0000_2000, 16'h0000, 0, 32'h0000_2000};
        vecs[2] = '{3'd4, 32'h8000_0000, 32'h0, 32'h0000_0000, 16'hFFFF, 1, 32'hFFFF_FFFC};
        vecs[3] = '{3'd2, 32'h0, 32'h7, 32'h0000_0040, 16'h8000, 1, 32'hFFFE_0040};
        vecs[4] = '{3'd2, 32'h1, 32'h0, 32'h0000_0040, 16'h7FFF, 0, 32'h0002_003C};
        vecs[5] = '{3'd5, 32'hFFFF_FFFF, 32'h0, 32'h0000_0010, 16'h0001, 0, 32'h0000_0014};
        vecs[6] = '{3'd3, 32'h0, 32'h0, 32'h0000_0010, 16'h0001, 0, 32'h0000_0014};
        vecs[7] = '{3'd6, 32'h0, 32'h0, 32'h0000_0010, 16'h0001, 0, 32'h0000_0014};
        vecs[8] = '{3'd7, 32'h5, 32'h5, 32'h0000_0010, 16'h0001, 0, 32'h0000_0014};
        vecs[9] = '{3'd0, 32'hAAAA_0000, 32'hAAAA_0000, 32'hFFFF_FFFC, 16'h0001, 1, 32'h0000_0000};
        foreach (vecs[k]) begin
            do_branch(vecs[k].t, vecs[k].rs, vecs[k].rt, vecs[k].pc, vecs[k].imm, 0, nst, rs_seen, tk, tgt, fl);
            chk($sformatf("v%0d_taken", k), tk, vecs[k].taken);
            chk($sformatf("v%0d_target", k), tgt, vecs[k].target);
            chk($sformatf("v%0d_flush", k), fl, vecs[k].taken);
        end

        // Operand wait with a fresh counter
        reset = 1'b1; step(); reset = 1'b0;
        do_branch(3'b011, 32'h0000_0001, 32'h0, 32'h0000_0100, 16'h0010, 3, nst, rs_seen, tk, tgt, fl);
        chk("t3_stall_cycles", nst, 5);
        chk("t3_taken", tk, 1);
        chk("t3_cnt", bus.stall_cnt, 5);

        // kill during WAIT
        bus.br_valid = 1; bus.br_type = 3'b001; bus.rs_val = 32'h1; bus.rt_val = 32'h2;
        bus.rs_ready = 1; bus.rt_ready = 0;
        step();
        bus.kill = 1;
        @(negedge clk);
        chk("t5_wait_stall", bus.stall_id, 1);
        step();
        bus.kill = 0; bus.br_valid = 0; bus.rt_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_kill_idle", bus.stall_id, 0);
            chk("t5_kill_nores", bus.resolve_valid, 0);
            step();
        end
        // kill together with a ready branch
        bus.br_valid = 1; bus.kill = 1;
        step();
        bus.br_valid = 0; bus.kill = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_coinc_idle", bus.stall_id, 0);
            chk("t5_coinc_nores", bus.resolve_valid, 0);
            step();
        end
        do_branch(3'b001, 32'h1, 32'h2, 32'h0000_0500, 16'h0001, 0, nst, rs_seen, tk, tgt, fl);
        chk("t5_after_taken", tk, 1);
        chk("t5_after_target", tgt, 32'h0000_0504);

        // Back-to-back: second branch presented in the resolve cycle of the first
        bus.br_valid = 1; bus.br_type = 3'b001; bus.rs_val = 32'h1; bus.rt_val = 32'h2;
        bus.pc_plus4 = 32'h0000_0100; bus.imm16 = 16'h0002; bus.rs_ready = 1; bus.rt_ready = 1;
        step();
        bus.br_valid = 0;
        step();
        bus.br_valid = 1; bus.br_type = 3'b000; bus.rs_val = 32'h7; bus.rt_val = 32'h7;
        bus.pc_plus4 = 32'h0000_0200; bus.imm16 = 16'hFFFE;
        @(negedge clk);
        chk("t6_a_resolve", bus.resolve_valid, 1);
        chk("t6_a_target", bus.br_target, 32'h0000_0108);
        chk("t6_b_stall", bus.stall_id, 1);
        step();
        bus.br_valid = 0;
        @(negedge clk);
        chk("t6_b_eval_nores", bus.resolve_valid, 0);
        step();
        @(negedge clk);
        chk("t6_b_resolve", bus.resolve_valid, 1);
        chk("t6_b_taken", bus.br_taken, 1);
        chk("t6_b_target", bus.br_target, 32'h0000_01F8);
        step();

        // Reset while in EVAL
        bus.br_valid = 1; bus.br_type = 3'b101; bus.rs_val = 32'h0;
        step();
        bus.br_valid = 0; reset = 1;
        step();
        reset = 0;
        @(negedge clk);
        chk("t6_rst_resolve", bus.resolve_valid, 0);
        chk("t6_rst_taken", bus.br_taken, 0);
        chk("t6_rst_target", bus.br_target, 0);
        chk("t6_rst_flush", bus.flush_if, 0);
        chk("t6_rst_cnt", bus.stall_cnt, 0);
        chk("t6_rst_stall", bus.stall_id, 0);
        repeat (3) step();

        // Counter saturation under a long operand wait
        bus.br_valid = 1; bus.rt_ready = 0;
        repeat (70) step();
        @(negedge clk);
        chk("sat_cnt", bus.stall_cnt, CNT_MAX);
        bus.kill = 1; bus.br_valid = 0;
        step();
        bus.kill = 0;
        repeat (3) step();
        @(negedge clk);
        chk("sat_hold_after_kill", bus.stall_cnt, CNT_MAX);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
